// File: rtl/vlsu_shuffle_fifo_unit.sv
// rtl/vlsu_shuffle_fifo_unit.sv - VLSU load shuffle stage with per-lane output FIFOs
// Optional feature macro: VLSU_SHF_SKIP_IDLE_EN (lanes whose beat has no enabled nibble skip the push).
module vlsu_shuffle_fifo_unit #(
    parameter int NrExits       = 4,
    parameter int NbPerLane     = 16,
    parameter int InfoDepth     = 4,
    parameter int LaneFifoDepth = 2,
    parameter int ReqIdBits     = 3,
    parameter int CntBits       = 16,
    parameter int VAddrSetBits  = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              seq_valid_i,
    output logic                              seq_ready_o,
    input  logic [NrExits*NbPerLane*4-1:0]    seq_nb_i,
    input  logic [NrExits*NbPerLane-1:0]      seq_en_i,
    input  logic                              info_valid_i,
    output logic                              info_ready_o,
    input  logic [ReqIdBits-1:0]              info_req_id_i,
    input  logic [1:0]                        info_sew_i,
    input  logic                              info_vm_i,
    input  logic [CntBits-1:0]                info_cmt_cnt_i,
    input  logic [VAddrSetBits-1:0]           info_vaddr_set_i,
    input  logic [NrExits-1:0]                mask_valid_i,
    input  logic [NrExits*NbPerLane-1:0]      mask_bits_i,
    output logic                              mask_ready_o,
    output logic [NrExits-1:0]                tx_valid_o,
    input  logic [NrExits-1:0]                tx_ready_i,
    output logic [NrExits*NbPerLane*4-1:0]    tx_data_o,
    output logic [NrExits*NbPerLane-1:0]      tx_nbe_o,
    output logic [NrExits*ReqIdBits-1:0]      tx_req_id_o,
    output logic [NrExits*VAddrSetBits-1:0]   tx_vaddr_set_o,
    output logic                              done_valid_o,
    output logic [ReqIdBits-1:0]              done_req_id_o
);
    localparam int NbTot = NrExits * NbPerLane;
    localparam int LaneW = NbPerLane * 4;
    localparam int IPtrW = $clog2(InfoDepth);
    localparam int LPtrW = $clog2(LaneFifoDepth);

    logic [ReqIdBits-1:0]    iq_req_id [InfoDepth];
    logic [1:0]              iq_sew    [InfoDepth];
    logic                    iq_vm     [InfoDepth];
    logic [CntBits-1:0]      iq_cnt    [InfoDepth];
    logic [VAddrSetBits-1:0] iq_vaddr  [InfoDepth];
    logic [IPtrW:0]          iq_wp, iq_rp;
    logic [IPtrW-1:0]        hp;
    logic                    iq_empty, iq_full, info_push, commit, head_pop;
    logic [NrExits-1:0]      lane_full;

    logic [ReqIdBits-1:0]    head_req_id;
    logic [1:0]              head_sew;
    logic                    head_vm;
    logic [CntBits-1:0]      head_cnt;
    logic [VAddrSetBits-1:0] head_vaddr;

    assign hp          = iq_rp[IPtrW-1:0];
    assign head_req_id = iq_req_id[hp];
    assign head_sew    = iq_sew[hp];
    assign head_vm     = iq_vm[hp];
    assign head_cnt    = iq_cnt[hp];
    assign head_vaddr  = iq_vaddr[hp];

    assign iq_empty     = (iq_wp == iq_rp);
    assign iq_full      = (iq_wp == {~iq_rp[IPtrW], iq_rp[IPtrW-1:0]});
    assign info_ready_o = !iq_full;
    assign info_push    = info_valid_i && !iq_full;

    // Gating with rst_i keeps a reset cycle from committing or pulsing done.
    assign seq_ready_o   = !rst_i && !iq_empty && !(|lane_full) && (head_vm || &mask_valid_i);
    assign commit        = seq_valid_i && seq_ready_o;
    assign head_pop      = commit && (head_cnt == '0);
    assign mask_ready_o  = commit && !head_vm;
    assign done_valid_o  = head_pop;
    assign done_req_id_o = head_req_id;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            iq_wp <= '0;
            iq_rp <= '0;
            for (int i = 0; i < InfoDepth; i++) begin
                iq_req_id[i] <= '0;
                iq_sew[i]    <= '0;
                iq_vm[i]     <= 1'b0;
                iq_cnt[i]    <= '0;
                iq_vaddr[i]  <= '0;
            end
        end else begin
            if (info_push) begin
                iq_req_id[iq_wp[IPtrW-1:0]] <= info_req_id_i;
                iq_sew[iq_wp[IPtrW-1:0]]    <= info_sew_i;
                iq_vm[iq_wp[IPtrW-1:0]]     <= info_vm_i;
                iq_cnt[iq_wp[IPtrW-1:0]]    <= info_cmt_cnt_i;
                iq_vaddr[iq_wp[IPtrW-1:0]]  <= info_vaddr_set_i;
                iq_wp                       <= iq_wp + 1'b1;
            end
            if (commit) begin
                iq_vaddr[hp] <= head_vaddr + 1'b1;
                if (head_pop) iq_rp <= iq_rp + 1'b1;
                else          iq_cnt[hp] <= head_cnt - 1'b1;
            end
        end
    end

    // Every element width gets its own fixed wiring; the head's sew picks one.
    logic [3:0][NrExits-1:0][LaneW-1:0]     shf_data;
    logic [3:0][NrExits-1:0][NbPerLane-1:0] shf_en;
    logic [NrExits-1:0][LaneW-1:0]          lane_data;
    logic [NrExits-1:0][NbPerLane-1:0]      lane_nbe;

    for (genvar c = 0; c < 4; c++) begin : g_sew
        for (genvar l = 0; l < NrExits; l++) begin : g_l
            for (genvar o = 0; o < NbPerLane; o++) begin : g_o
                localparam int E = 2 << c;
                localparam int S = ((o / E) * NrExits + l) * E + (o % E);
                if (S < NbTot) begin : g_map
                    assign shf_data[c][l][4*o +: 4] = seq_nb_i[4*S +: 4];
                    assign shf_en[c][l][o]          = seq_en_i[S];
                end else begin : g_none
                    assign shf_data[c][l][4*o +: 4] = 4'h0;
                    assign shf_en[c][l][o]          = 1'b0;
                end
            end
        end
    end

    for (genvar l = 0; l < NrExits; l++) begin : g_lane
        logic [LaneW-1:0]        f_data  [LaneFifoDepth];
        logic [NbPerLane-1:0]    f_nbe   [LaneFifoDepth];
        logic [ReqIdBits-1:0]    f_req   [LaneFifoDepth];
        logic [VAddrSetBits-1:0] f_vaddr [LaneFifoDepth];
        logic [LPtrW:0]          wp, rp;
        logic                    empty, push, pop;

        assign lane_data[l] = shf_data[head_sew][l];
        assign lane_nbe[l]  = shf_en[head_sew][l]
                            & (head_vm ? {NbPerLane{1'b1}} : mask_bits_i[l*NbPerLane +: NbPerLane]);

        assign empty        = (wp == rp);
        assign lane_full[l] = (wp == {~rp[LPtrW], rp[LPtrW-1:0]});
        assign pop          = !empty && tx_ready_i[l];
`ifdef VLSU_SHF_SKIP_IDLE_EN
        assign push = commit && (|lane_nbe[l]);
`else
        assign push = commit;
`endif

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wp <= '0;
                rp <= '0;
                for (int i = 0; i < LaneFifoDepth; i++) begin
                    f_data[i]  <= '0;
                    f_nbe[i]   <= '0;
                    f_req[i]   <= '0;
                    f_vaddr[i] <= '0;
                end
            end else begin
                if (push) begin
                    f_data[wp[LPtrW-1:0]]  <= lane_data[l];
                    f_nbe[wp[LPtrW-1:0]]   <= lane_nbe[l];
                    f_req[wp[LPtrW-1:0]]   <= head_req_id;
                    f_vaddr[wp[LPtrW-1:0]] <= head_vaddr;
                    wp                     <= wp + 1'b1;
                end
                if (pop) rp <= rp + 1'b1;
            end
        end

        assign tx_valid_o[l]                                 = !empty;
        assign tx_data_o[l*LaneW +: LaneW]                   = f_data[rp[LPtrW-1:0]];
        assign tx_nbe_o[l*NbPerLane +: NbPerLane]            = f_nbe[rp[LPtrW-1:0]];
        assign tx_req_id_o[l*ReqIdBits +: ReqIdBits]         = f_req[rp[LPtrW-1:0]];
        assign tx_vaddr_set_o[l*VAddrSetBits +: VAddrSetBits] = f_vaddr[rp[LPtrW-1:0]];
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) assert (!(seq_valid_i && iq_empty));
    end
`endif
endmodule

// File: tb/tb_vlsu_shuffle_fifo_unit.sv
// tb/tb_vlsu_shuffle_fifo_unit.sv - randomized and directed bench for vlsu_shuffle_fifo_unit
module tb_vlsu_shuffle_fifo_unit;
    localparam int N = 4, NB = 16, ID = 4, LFD = 2, RB = 3, CB = 16, VB = 8;
    localparam int DW = N * NB * 4, EW = N * NB;

    logic clk_i = 1'b0;
    logic rst_i;
    logic seq_valid_i, seq_ready_o;
    logic [DW-1:0] seq_nb_i;
    logic [EW-1:0] seq_en_i;
    logic info_valid_i, info_ready_o;
    logic [RB-1:0] info_req_id_i;
    logic [1:0] info_sew_i;
    logic info_vm_i;
    logic [CB-1:0] info_cmt_cnt_i;
    logic [VB-1:0] info_vaddr_set_i;
    logic [N-1:0] mask_valid_i;
    logic [EW-1:0] mask_bits_i;
    logic mask_ready_o;
    logic [N-1:0] tx_valid_o, tx_ready_i;
    logic [DW-1:0] tx_data_o;
    logic [EW-1:0] tx_nbe_o;
    logic [N*RB-1:0] tx_req_id_o;
    logic [N*VB-1:0] tx_vaddr_set_o;
    logic done_valid_o;
    logic [RB-1:0] done_req_id_o;

    always #5 clk_i = ~clk_i;

    vlsu_shuffle_fifo_unit dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .seq_valid_i(seq_valid_i), .seq_ready_o(seq_ready_o),
        .seq_nb_i(seq_nb_i), .seq_en_i(seq_en_i),
        .info_valid_i(info_valid_i), .info_ready_o(info_ready_o),
        .info_req_id_i(info_req_id_i), .info_sew_i(info_sew_i), .info_vm_i(info_vm_i),
        .info_cmt_cnt_i(info_cmt_cnt_i), .info_vaddr_set_i(info_vaddr_set_i),
        .mask_valid_i(mask_valid_i), .mask_bits_i(mask_bits_i), .mask_ready_o(mask_ready_o),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .tx_data_o(tx_data_o), .tx_nbe_o(tx_nbe_o),
        .tx_req_id_o(tx_req_id_o), .tx_vaddr_set_o(tx_vaddr_set_o),
        .done_valid_o(done_valid_o), .done_req_id_o(done_req_id_o)
    );

    typedef struct {
        logic [RB-1:0] req_id;
        logic [1:0]    sew;
        logic          vm;
        int            cnt;
        logic [VB-1:0] vaddr;
    } info_t;

    typedef struct {
        logic [NB*4-1:0] data;
        logic [NB-1:0]   nbe;
        logic [RB-1:0]   req_id;
        logic [VB-1:0]   vaddr;
    } lane_t;

    info_t iq[$];
    lane_t lq[N][$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic lane_t mk_entry(input int l, input info_t h);
        lane_t e;
        int E, s;
        E = 2 << h.sew;
        for (int o = 0; o < NB; o++) begin
            s = ((o / E) * N + l) * E + (o % E);
            e.data[4*o +: 4] = seq_nb_i[4*s +: 4];
            e.nbe[o] = seq_en_i[s] && (h.vm || mask_bits_i[l*NB + o]);
        end
        e.req_id = h.req_id;
        e.vaddr  = h.vaddr;
        return e;
    endfunction

    function automatic logic exp_ready();
        logic r;
        r = !rst_i && iq.size() > 0;
        if (r) r = iq[0].vm || (&mask_valid_i);
        for (int l = 0; l < N; l++) if (lq[l].size() >= LFD) r = 1'b0;
        return r;
    endfunction

    task automatic check_outputs();
        logic rdy, cm;
        rdy = exp_ready();
        cm  = rdy && seq_valid_i;
        chk("seq_ready", seq_ready_o, rdy);
        chk("info_ready", info_ready_o, iq.size() < ID);
        chk("mask_ready", mask_ready_o, cm ? !iq[0].vm : 1'b0);
        chk("done_valid", done_valid_o, cm ? (iq[0].cnt == 0) : 1'b0);
        if (cm && iq[0].cnt == 0) chk("done_req_id", done_req_id_o, iq[0].req_id);
        for (int l = 0; l < N; l++) begin
            chk("tx_valid", tx_valid_o[l], lq[l].size() > 0);
            if (lq[l].size() > 0) begin
                chk("tx_data", tx_data_o[l*NB*4 +: NB*4], lq[l][0].data);
                chk("tx_nbe", tx_nbe_o[l*NB +: NB], lq[l][0].nbe);
                chk("tx_req_id", tx_req_id_o[l*RB +: RB], lq[l][0].req_id);
                chk("tx_vaddr", tx_vaddr_set_o[l*VB +: VB], lq[l][0].vaddr);
            end
        end
    endtask

    // One clock: check outputs before the edge, then advance the reference model.
    task automatic step();
        logic cm, enq;
        logic [N-1:0] pop;
        lane_t ent[N];
        info_t h, ni;
        #1;
        check_outputs();
        cm  = exp_ready() && seq_valid_i;
        enq = info_valid_i && iq.size() < ID;
        for (int l = 0; l < N; l++) pop[l] = lq[l].size() > 0 && tx_ready_i[l];
        if (cm) begin
            h = iq[0];
            for (int l = 0; l < N; l++) ent[l] = mk_entry(l, h);
        end
        ni.req_id = info_req_id_i; ni.sew = info_sew_i; ni.vm = info_vm_i;
        ni.cnt = int'(info_cmt_cnt_i); ni.vaddr = info_vaddr_set_i;
        @(posedge clk_i);
        if (rst_i) begin
            iq.delete();
            for (int l = 0; l < N; l++) lq[l].delete();
        end else begin
            for (int l = 0; l < N; l++) if (pop[l]) void'(lq[l].pop_front());
            if (cm) begin
                for (int l = 0; l < N; l++) begin
`ifdef VLSU_SHF_SKIP_IDLE_EN
                    if (ent[l].nbe != '0) lq[l].push_back(ent[l]);
`else
                    lq[l].push_back(ent[l]);
`endif
                end
                if (h.cnt == 0) void'(iq.pop_front());
                else begin
                    h.cnt = h.cnt - 1;
                    h.vaddr = h.vaddr + 1'b1;
                    iq[0] = h;
                end
            end
            if (enq) iq.push_back(ni);
        end
        @(negedge clk_i);
    endtask

    task automatic put_info(input int req, input int sew, input logic vm, input int cnt, input int va);
        info_valid_i = 1'b1;
        info_req_id_i = RB'(req); info_sew_i = 2'(sew); info_vm_i = vm;
        info_cmt_cnt_i = CB'(cnt); info_vaddr_set_i = VB'(va);
        step();
        info_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 64 && iq.size() > 0; c++) begin
            seq_valid_i = 1'b1;
            step();
        end
        seq_valid_i = 1'b0;
        if (iq.size() != 0) chk("drain_timeout", iq.size(), 0);
    endtask

    initial begin
        int ndone;
        rst_i = 1'b1; seq_valid_i = 1'b0; info_valid_i = 1'b0;
        seq_nb_i = '0; seq_en_i = '1; info_req_id_i = '0; info_sew_i = '0; info_vm_i = 1'b1;
        info_cmt_cnt_i = '0; info_vaddr_set_i = '0; mask_valid_i = '0; mask_bits_i = '0;
        tx_ready_i = '1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_seq_ready", seq_ready_o, 0);
        chk("rst_tx_valid", tx_valid_o, 0);
        chk("rst_info_ready", info_ready_o, 1);
        chk("rst_tx_data", tx_data_o, 0);
        chk("rst_tx_nbe", tx_nbe_o, 0);
        chk("rst_tx_req_vaddr", {tx_req_id_o, tx_vaddr_set_o}, 0);
        chk("rst_done", {done_valid_o, done_req_id_o, mask_ready_o}, 0);

        // Unmasked byte elements: nibble n carries n%16.
        for (int n = 0; n < EW; n++) seq_nb_i[4*n +: 4] = 4'(n % 16);
        put_info(3, 0, 1'b1, 0, 5);
        seq_valid_i = 1'b1;
        #1;
        chk("t1_done_valid", done_valid_o, 1);
        chk("t1_done_id", done_req_id_o, 3);
        step();
        seq_valid_i = 1'b0;
        #1;
        chk("t1_lane1_nib01", tx_data_o[NB*4 +: 8], 8'h32);
        chk("t1_vaddr_all", tx_vaddr_set_o, {4{8'd5}});
        step();

        // Masked word elements: partial mask_valid stalls, then lane 0 nbe follows the mask.
        put_info(1, 2, 1'b0, 0, 9);
        mask_valid_i = 4'b0111;
        mask_bits_i = {{3{16'hFFFF}}, 16'h00FF};
        seq_valid_i = 1'b1;
        step(); step();
        #1;
        chk("t2_mask_stall", seq_ready_o, 0);
        mask_valid_i = 4'b1111;
        #1;
        chk("t2_mask_ready", mask_ready_o, 1);
        step();
        seq_valid_i = 1'b0;
        #1;
        chk("t2_lane0_nbe", tx_nbe_o[0 +: NB], 16'h00FF);
        chk("t2_mask_ready_once", mask_ready_o, 0);
        step();
        mask_valid_i = '0;

        // Multi-beat instruction and vaddr_set wrap.
        put_info(5, 1, 1'b1, 3, 5);
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            seq_valid_i = 1'b1;
            #1;
            if (done_valid_o) ndone++;
            if (i == 3) chk("t3_done_last", done_valid_o, 1);
            step();
            #1;
            chk("t3_vaddr", tx_vaddr_set_o[0 +: VB], 5 + i);
        end
        seq_valid_i = 1'b0;
        chk("t3_done_count", ndone, 1);
        put_info(6, 0, 1'b1, 1, 255);
        seq_valid_i = 1'b1;
        step(); step();
        seq_valid_i = 1'b0;
        #1;
        chk("t3_vaddr_wrap", tx_vaddr_set_o[0 +: VB], 0);
        step(); step();

        // Lane 2 stalled: two commits fit, then backpressure until release.
        tx_ready_i = 4'b1011;
        put_info(2, 0, 1'b1, 3, 20);
        seq_valid_i = 1'b1;
        step(); step();
        #1;
        chk("t4_stall", seq_ready_o, 0);
        chk("t4_tx_valid_full", tx_valid_o, 4'b1111);
        step();
        #1;
        chk("t4_others_drained", tx_valid_o, 4'b0100);
        tx_ready_i = 4'b1111;
        #1;
        chk("t4_no_passthru", seq_ready_o, 0);
        step();
        #1;
        chk("t4_resume", seq_ready_o, 1);
        drain();
        step(); step();

        // Full info queue ignores an offered enqueue even while popping.
        for (int i = 0; i < ID; i++) put_info(i, 0, 1'b1, 0, 40 + i);
        #1;
        chk("t5_info_full", info_ready_o, 0);
        info_valid_i = 1'b1; info_req_id_i = 3'd7;
        seq_valid_i = 1'b1;
        step();
        info_valid_i = 1'b0; seq_valid_i = 1'b0;
        #1;
        chk("t5_info_ready_after", info_ready_o, 1);
        drain();
        step(); step();

        // Reset with lane FIFOs half full.
        tx_ready_i = '0;
        put_info(4, 0, 1'b1, 1, 30);
        seq_valid_i = 1'b1;
        step();
        rst_i = 1'b1;
        #1;
        chk("t6_rst_no_done", done_valid_o, 0);
        step();
        rst_i = 1'b0; seq_valid_i = 1'b0; tx_ready_i = '1;
        #1;
        chk("t6_tx_valid", tx_valid_o, 0);
        chk("t6_info_ready", info_ready_o, 1);
        step();

        // Randomized traffic against the reference model.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rst_i = ($urandom_range(0, 299) == 0);
            info_valid_i = ($urandom_range(0, 2) == 0);
            info_req_id_i = RB'($urandom()); info_sew_i = 2'($urandom()); info_vm_i = 1'($urandom());
            info_cmt_cnt_i = CB'($urandom_range(0, 3)); info_vaddr_set_i = VB'($urandom());
            seq_valid_i = (iq.size() > 0) && ($urandom_range(0, 3) != 0);
            for (int w = 0; w < DW / 32; w++) seq_nb_i[w*32 +: 32] = $urandom();
            for (int w = 0; w < EW / 32; w++) begin
                seq_en_i[w*32 +: 32] = $urandom();
                mask_bits_i[w*32 +: 32] = $urandom();
            end
            mask_valid_i = ($urandom_range(0, 3) == 0) ? N'($urandom()) : '1;
            tx_ready_i = N'($urandom());
            step();
        end
        rst_i = 1'b0; seq_valid_i = 1'b0; info_valid_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
